// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
//
// Sequences MEM-stage data accesses against a variable-latency memory that uses
// a req/ack handshake. While an access is outstanding the pipeline is frozen
// (stall_o) and a bubble is forced into MEM/WB (wb_bubble_o), so a load or
// store is written back exactly once. Load data is captured for writeback.
// A saturating stall-cycle counter and a sticky timeout flag are also kept.
//
// Ports
//   clk_i        in   clock, all state on rising edge
//   rst_i        in   synchronous active-high reset
//   MemRead_i    in   MEM-stage load request
//   MemWrite_i   in   MEM-stage store request (wins over MemRead_i)
//   addr_i       in   MEM-stage byte address
//   wdata_i      in   MEM-stage store data
//   mem_ack_i    in   memory completion strobe (meaningful only in REQ)
//   mem_rdata_i  in   memory read data, valid with mem_ack_i
//   mem_req_o    out  memory request (registered)
//   mem_we_o     out  1 = write (registered)
//   mem_addr_o   out  latched address (registered)
//   mem_wdata_o  out  latched store data (registered)
//   stall_o      out  freeze PC/IF_ID/ID_EX/EX_MEM (combinational)
//   wb_bubble_o  out  zero MEM_WB RegWrite/MemtoReg, identical to stall_o
//   rdata_o      out  last load data (registered)
//   err_o        out  sticky timeout flag
//   stall_cnt_o  out  saturating count of cycles with stall_o = 1
// -----------------------------------------------------------------------------
module mem_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             stall_o,
    output logic             wb_bubble_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Timeout counter holds 0..TIMEOUT-1; keep it at least one bit wide.
    localparam int TMO_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             r_state;
    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [TMO_W-1:0]   r_tmo;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic               w_req_nxt;
    logic               w_we_nxt;
    logic [31:0]        w_addr_nxt;
    logic [31:0]        w_wdata_nxt;
    logic [31:0]        w_rdata_nxt;
    logic               w_err_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_access;
    logic               w_stall;

    // State register and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_tmo   <= w_tmo_nxt;
            // Saturate rather than wrap so a long stall never looks short.
            if (w_stall && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and stall decode.
    always_comb begin
        w_access    = MemRead_i | MemWrite_i;
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_tmo_nxt   = r_tmo;
        w_stall     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // mem_ack_i is deliberately ignored here: a late ack from an
                // access aborted by reset must not leak into rdata_o.
                if (w_access) begin
                    w_stall     = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = MemWrite_i;
                    w_addr_nxt  = addr_i;
                    w_wdata_nxt = wdata_i;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                w_stall = 1'b1;
                if (mem_ack_i) begin
                    w_req_nxt = 1'b0;
                    if (!r_we) begin
                        w_rdata_nxt = mem_rdata_i;
                    end
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else if (r_tmo == TMO_LAST) begin
                    // Abort: release the pipeline with zero load data.
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end

            S_DONE: begin
                // The finished access is still on the MEM inputs this cycle;
                // never restart it. The next instruction arrives on this edge.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign stall_o     = w_stall;
    assign wb_bubble_o = w_stall;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign stall_cnt_o = r_cnt;

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Sequences data-memory accesses issued by the MEM stage against a variable-latency memory with a req/ack handshake.
- Freezes the pipeline (stall_o) while an access is outstanding.
- Forces a bubble into the MEM/WB pipeline register while stalled, so no register-file write happens twice.
- Returns captured read data for writeback and keeps a stall-cycle performance counter plus a sticky timeout error.

Parameters:
TIMEOUT, 64, max cycles in REQ without mem_ack_i before abort (>=1)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
MemRead_i  in  1  MEM-stage load request
MemWrite_i  in  1  MEM-stage store request
addr_i  in  32  MEM-stage byte address
wdata_i  in  32  MEM-stage store data
mem_ack_i  in  1  memory completion strobe, valid only while mem_req_o=1
mem_rdata_i  in  32  memory read data, valid with mem_ack_i
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  1=write, registered
mem_addr_o  out  32  latched address, registered
mem_wdata_o  out  32  latched store data, registered
stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM, combinational
wb_bubble_o  out  1  force MEM_WB RegWrite_i/MemtoReg_i to 0, equals stall_o
rdata_o  out  32  last load data, registered
err_o  out  1  sticky timeout flag
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o=1

Behaviour:
- Reset (rst_i=1 at edge) sets all of the following; it has priority over every other event:
  - state=IDLE
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0
  - rdata_o=0, err_o=0, stall_cnt_o=0, timeout counter=0
- States IDLE, REQ, DONE.
- IDLE:
  - access = MemRead_i|MemWrite_i.
  - If access: latch addr_i, wdata_i, we=MemWrite_i into mem_* outputs, set mem_req_o=1, go REQ.
  - Both MemRead_i and MemWrite_i high: treated as a write.
  - mem_ack_i in IDLE is ignored.
- REQ:
  - mem_req_o held 1; mem_* outputs held constant.
  - On mem_ack_i=1: mem_req_o<=0; if !mem_we_o then rdata_o<=mem_rdata_i; go DONE; counter cleared.
  - Otherwise timeout counter increments.
  - When the counter reaches TIMEOUT-1 without ack (i.e. TIMEOUT REQ cycles elapse): mem_req_o<=0, err_o<=1, rdata_o<=0, go DONE.
  - err_o stays 1 until reset.
- DONE:
  - Exactly one cycle; stall_o=0 so the pipeline advances and MEM_WB captures rdata_o.
  - The access still visible on MemRead_i/MemWrite_i this cycle is not restarted.
  - Unconditionally go IDLE.
- stall_o = (state==IDLE && access) || state==REQ.
- Latency:
  - Ack on the first REQ cycle gives 2 stall cycles, with DONE on the 3rd cycle.
  - An ack after k extra REQ cycles gives 2+k stall cycles.
- Back-to-back accesses: the next instruction reaches MEM on the edge leaving DONE; IDLE then accepts it in that same cycle, giving no dead cycle beyond DONE.
- Store ack leaves rdata_o unchanged.
- stall_cnt_o increments by 1 on each edge where stall_o=1, saturating at 2^CNT_W-1 with no wrap.
- Reset mid-REQ:
  - mem_req_o drops after that edge.
  - A late ack after reset arrives in IDLE and is ignored.
  - rdata_o is not updated.
- Inputs in REQ/DONE other than mem_ack_i/mem_rdata_i are don't-care; the latched values are used.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, stall_o=0, stall_cnt_o=0.
- Load addr=0x100; ack with rdata=0xCAFEF00D on 3rd REQ cycle:
  - stall_o=1 for 4 cycles, mem_addr_o=0x100, mem_we_o=0.
  - DONE cycle: rdata_o=0xCAFEF00D, stall_o=0.
  - stall_cnt_o=4.
- Store addr=0x200 wdata=0x12345678 with ack in the first REQ cycle:
  - stall 2 cycles, mem_we_o=1, mem_wdata_o=0x12345678.
  - rdata_o keeps its prior value; wb_bubble_o mirrors stall_o.
- TIMEOUT=4, load with no ack:
  - exactly 4 REQ cycles, then mem_req_o=0, err_o=1, rdata_o=0, DONE.
  - err_o stays 1 through a later successful access until rst_i.
- Reset asserted on 2nd REQ cycle, ack given the cycle after:
  - state IDLE, mem_req_o=0, rdata_o unchanged from 0, stall_o=0.
- CNT_W=3, 3 back-to-back loads each acked on 2nd REQ cycle:
  - the next access starts in the cycle right after each DONE.
  - stall_cnt_o saturates at 7 without wrapping.
